ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: host-request sequence, 11-bit frame, device ack check.
// Owns the open-drain pins only between acceptance and done.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_CYCLES   = 50,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clock_i,
    input  logic       ps2_data_i,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int unsigned PH_MAX  = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int unsigned PH_W    = $clog2(PH_MAX + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned EDGE_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           ck_sync_q, dt_sync_q;
    logic                 ck_prev_q;
    logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [EDGE_W-1:0]    edge_q, edge_d;
    logic [FRAME_W-1:0]   sh_q, sh_d;
    logic                 clock_oe_q, clock_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 ready_q, ready_d;
    logic                 ck_s, dt_s, fall;

    // Pin synchronizers; the idle bus is high, so reset to 1 avoids a false edge.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            ck_sync_q <= 2'b11;
            dt_sync_q <= 2'b11;
            ck_prev_q <= 1'b1;
        end else begin
            ck_sync_q <= {ck_sync_q[0], ps2_clock_i};
            dt_sync_q <= {dt_sync_q[0], ps2_data_i};
            ck_prev_q <= ck_sync_q[1];
        end
    end

    assign ck_s = ck_sync_q[1];
    assign dt_s = dt_sync_q[1];
    assign fall = ck_prev_q & ~ck_s;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ph_cnt_q   <= '0;
            to_cnt_q   <= '0;
            edge_q     <= '0;
            sh_q       <= '0;
            clock_oe_q <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            to_cnt_q   <= to_cnt_d;
            edge_q     <= edge_d;
            sh_q       <= sh_d;
            clock_oe_q <= clock_oe_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_cnt_d   = ph_cnt_q;
        to_cnt_d   = to_cnt_q;
        edge_d     = edge_q;
        sh_d       = sh_q;
        clock_oe_d = clock_oe_q;
        data_oe_d  = data_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_d      = ack_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                clock_oe_d = 1'b0;
                data_oe_d  = 1'b0;
                if (tx_valid && ready_q) begin
                    sh_d       = {1'b1, ~^tx_data, tx_data};
                    ph_cnt_d   = '0;
                    clock_oe_d = 1'b1;
                    busy_d     = 1'b1;
                    ack_d      = 1'b0;
                    err_d      = 1'b0;
                    state_d    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ph_cnt_d = ph_cnt_q + PH_W'(1);
                if (ph_cnt_q == PH_W'(INHIBIT_CYCLES - 1)) begin
                    ph_cnt_d  = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                ph_cnt_d = ph_cnt_q + PH_W'(1);
                if (ph_cnt_q == PH_W'(START_CYCLES - 1)) begin
                    ph_cnt_d   = '0;
                    clock_oe_d = 1'b0;
                    edge_d     = '0;
                    to_cnt_d   = '0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // Line level equals the frame bit, so pull low on a 0; stop bit releases data.
                if (fall) begin
                    data_oe_d = ~sh_q[0];
                    sh_d      = {1'b0, sh_q[FRAME_W-1:1]};
                    edge_d    = edge_q + EDGE_W'(1);
                    if (edge_q == EDGE_W'(FRAME_W - 1)) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (fall) begin
                    ack_d   = ~dt_s;
                    err_d   = dt_s;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (ck_s && dt_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                clock_oe_d = 1'b0;
                data_oe_d  = 1'b0;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        // Device never finished the frame: abandon the bus and report failure.
        if ((state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT_IDLE) &&
            to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            clock_oe_d = 1'b0;
            data_oe_d  = 1'b0;
            ack_d      = 1'b0;
            err_d      = 1'b1;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
        end

        ready_d = (state_d == S_IDLE) && !done_d;
    end

    assign tx_ready     = ready_q;
    assign ps2_clock_oe = clock_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ack_ok       = ack_q;
    assign error        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model, window-based output model
// checked every cycle, plus directed frames with literal expected bit patterns.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int ST   = 5;
    localparam int TO   = 2000;
    localparam int HALF = 30;

    logic       clk_in   = 1'b0;
    logic       reset_n  = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready, ps2_clock_oe, ps2_data_oe, busy, done, ack_ok, error;
    logic       dev_clk  = 1'b0;
    logic       dev_dat  = 1'b0;
    logic       ps2_clock_i, ps2_data_i;

    assign ps2_clock_i = ~(ps2_clock_oe | dev_clk);
    assign ps2_data_i  = ~(ps2_data_oe | dev_dat);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_CYCLES  (ST),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clock_i (ps2_clock_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clock_oe(ps2_clock_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .error       (error)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Model state
    bit m_busy  = 1'b0;
    int m_t     = 0;
    int exp_done_cyc = 0;
    bit exp_ack = 1'b0;
    bit exp_err = 1'b0;
    bit exp_to  = 1'b0;
    int ndone   = 0;
    int last_done_cyc = 0;
    int cnt_ck  = 0;
    int cnt_st  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    // Per-cycle check of outputs against acceptance-relative time windows
    always @(negedge clk_in) begin : cmp
        bit ended;
        ended = 1'b0;
        if (!reset_n) begin
            chk("rst_ready", tx_ready, 1);
            chk("rst_lines", {ps2_clock_oe, ps2_data_oe}, 0);
            chk("rst_flags", {busy, done, ack_ok, error}, 0);
            m_busy = 1'b0;
            exp_done_cyc = 0;
        end else begin
            if (done) begin
                ndone++;
                last_done_cyc = cyc;
                ended = 1'b1;
                chk("done_expected", m_busy, 1);
                chk("done_after_start", (cyc > m_t + INH + ST), 1);
                chk("ack_ok", ack_ok, exp_ack);
                chk("error", error, exp_err);
                if (exp_done_cyc != 0) chk("done_cycle", cyc, exp_done_cyc);
                m_busy = 1'b0;
                exp_done_cyc = 0;
            end else if (m_busy && exp_done_cyc != 0 && cyc >= exp_done_cyc) begin
                chk("done_missing", done, 1);
                exp_done_cyc = 0;
            end
            chk("busy", busy, m_busy);
            chk("tx_ready", tx_ready, !m_busy && !ended);
            chk("clock_oe", ps2_clock_oe, m_busy && cyc >= m_t + 1 && cyc <= m_t + INH + ST);
            if (!m_busy)                  chk("data_oe_idle", ps2_data_oe, 0);
            else if (cyc <= m_t + INH)    chk("data_oe_inhibit", ps2_data_oe, 0);
            else if (cyc <= m_t + INH + ST) chk("data_oe_start", ps2_data_oe, 1);
            if (m_busy && cyc == m_t + 1) chk("flags_cleared", {ack_ok, error}, 0);
            if (m_busy) begin
                cnt_ck += int'(ps2_clock_oe);
                cnt_st += int'(ps2_clock_oe & ps2_data_oe);
            end
            if (tx_valid && !m_busy && !ended) begin
                m_busy = 1'b1;
                m_t    = cyc;
                cnt_ck = 0;
                cnt_st = 0;
                if (exp_to) exp_done_cyc = cyc + 1 + INH + ST + TO;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, output int t_acc);
        int k;
        k = 0;
        while (!tx_ready && k < 5000) begin
            tick(1);
            k++;
        end
        chk("send_ready", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        t_acc    = cyc;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_release();
        int k;
        k = 0;
        while (!(!ps2_clock_oe && ps2_data_oe) && k < 5000) begin
            tick(1);
            k++;
        end
        chk("host_release", {ps2_clock_oe, ps2_data_oe}, 2'b01);
        tick(HALF);
    endtask

    task automatic dev_edge(output logic s);
        dev_clk = 1'b1;
        tick(HALF);
        dev_clk = 1'b0;
        s = ps2_data_i;
        tick(HALF);
    endtask

    task automatic dev_frame(input bit ack_low, output logic [9:0] bits);
        logic s;
        wait_release();
        for (int k = 0; k < 10; k++) begin
            dev_edge(s);
            bits[k] = s;
        end
        if (ack_low) dev_dat = 1'b1;
        dev_edge(s);
        tick(5);
        dev_dat = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget);
        int k;
        k = 0;
        while (ndone == n0 && k < budget) begin
            tick(1);
            k++;
        end
        chk("done_seen", ndone, n0 + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int n0;
        logic [9:0] bits;
        logic s;
        logic [7:0] vec_d [3];
        logic [9:0] vec_f [3];
        vec_d[0] = 8'hED; vec_f[0] = 10'b11_1110_1101;
        vec_d[1] = 8'h02; vec_f[1] = 10'b10_0000_0010;
        vec_d[2] = 8'h00; vec_f[2] = 10'b11_0000_0000;

        tick(3);
        reset_n = 1'b1;
        tick(2);
        chk("idle_ready", tx_ready, 1);

        // Spurious bus activity while idle
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b1;
            tick(4);
            dev_clk = 1'b0;
            dev_dat = i[0];
            tick(4);
        end
        dev_dat = 1'b0;
        tick(5);
        chk("idle_no_done", ndone, 0);
        chk("idle_lines", {ps2_clock_oe, ps2_data_oe}, 0);

        // Acknowledged frames
        exp_ack = 1'b1; exp_err = 1'b0; exp_to = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n0 = ndone;
            send(vec_d[i], t);
            dev_frame(1'b1, bits);
            wait_done(n0, 5000);
            chk("frame_model", bits, frame_of(vec_d[i]));
            chk("frame_literal", bits, vec_f[i]);
            tick(10);
        end

        // Missing acknowledge
        exp_ack = 1'b0; exp_err = 1'b1;
        n0 = ndone;
        send(8'hA5, t);
        dev_frame(1'b0, bits);
        wait_done(n0, 5000);
        chk("nack_frame", bits, frame_of(8'hA5));
        tick(10);

        // Device never clocks
        exp_to = 1'b1;
        n0 = ndone;
        send(8'h55, t);
        wait_done(n0, 10000);
        chk("timeout_latency", last_done_cyc - t, 2026);
        exp_to = 1'b0;
        tick(2);
        chk("timeout_lines", {ps2_clock_oe, ps2_data_oe}, 0);
        tick(10);

        // New byte offered mid-SEND must be dropped
        exp_ack = 1'b1; exp_err = 1'b0;
        n0 = ndone;
        send(8'h3C, t);
        fork
            dev_frame(1'b1, bits);
            begin
                tick(250);
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                tick(1);
                tx_valid = 1'b0;
            end
        join
        wait_done(n0, 5000);
        chk("busy_frame", bits, frame_of(8'h3C));
        chk("clock_oe_len", cnt_ck, 25);
        chk("start_len", cnt_st, 5);
        tick(3000);
        chk("single_done", ndone, n0 + 1);

        // Reset in the middle of the frame
        send(8'hC3, t);
        wait_release();
        for (int k = 0; k < 4; k++) dev_edge(s);
        dev_clk = 1'b1;
        tick(10);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_lines", {ps2_clock_oe, ps2_data_oe}, 0);
        chk("rst_async_busy", busy, 0);
        dev_clk = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        chk("post_reset_ready", tx_ready, 1);
        exp_ack = 1'b1; exp_err = 1'b0;
        n0 = ndone;
        send(8'h5A, t);
        dev_frame(1'b1, bits);
        wait_done(n0, 5000);
        chk("post_reset_frame", bits, frame_of(8'h5A));

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
